// File: rtl/bitgen_pkg.sv
// Shared codes and defaults for the layered bitmap pixel generator.
// Used by bitgen_layer and bitgen_layered.
package bitgen_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'b00,
    MODE_GLYPH    = 2'b01,
    MODE_INVERT   = 2'b10,
    MODE_DISABLED = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    CFG_XS    = 3'd0,
    CFG_XE    = 3'd1,
    CFG_YS    = 3'd2,
    CFG_YE    = 3'd3,
    CFG_MODE  = 3'd4,
    CFG_COLOR = 3'd5
  } cfg_field_e;

  localparam logic [23:0] BG_COLOR_DEF = 24'hF8F9FA;

endpackage

// File: rtl/bitgen_layer.sv
// One compositing layer: shadow/active config registers and the
// stage-1 region test with scaled, tiled glyph lookup.
module bitgen_layer
  import bitgen_pkg::*;
#(
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 8,
  parameter int CW      = 10,
  parameter int COLOR_W = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CW-1:0]              hcount,
  input  logic [CW-1:0]              vcount,
  input  logic                       frame_start,
  input  logic [GLYPH_W*GLYPH_H-1:0] glyph,
  input  logic                       we,
  input  logic [2:0]                 field,
  input  logic [COLOR_W-1:0]         wdata,
  input  logic                       hide,
  output logic                       hit,
  output logic [COLOR_W-1:0]         color
);

  localparam int IW = $clog2(GLYPH_W*GLYPH_H);

  typedef struct packed {
    logic [CW-1:0]      xs;
    logic [CW-1:0]      xe;
    logic [CW-1:0]      ys;
    logic [CW-1:0]      ye;
    mode_e              mode;
    logic [1:0]         scale;
    logic               blink;
    logic [COLOR_W-1:0] color;
  } regs_t;

  localparam regs_t REGS_RST = '{
    xs: '0, xe: '0, ys: '0, ye: '0,
    mode: MODE_DISABLED, scale: '0,
    blink: 1'b0, color: '0
  };

  regs_t shd_q, shd_d;
  regs_t act_q, act_d;
  logic  hit_q, hit_d;

  logic          in_x, in_y, on, pix;
  logic [CW-1:0] dx, dy;
  int            col, row, idx;

  // Commit reads shd_q, so a same-cycle write lands next frame.
  always_comb begin
    shd_d = shd_q;
    act_d = act_q;
    if (frame_start) act_d = shd_q;
    if (we) begin
      case (cfg_field_e'(field))
        CFG_XS:    shd_d.xs = wdata[CW-1:0];
        CFG_XE:    shd_d.xe = wdata[CW-1:0];
        CFG_YS:    shd_d.ys = wdata[CW-1:0];
        CFG_YE:    shd_d.ye = wdata[CW-1:0];
        CFG_MODE: begin
          shd_d.mode  = mode_e'(wdata[1:0]);
          shd_d.scale = wdata[3:2];
          shd_d.blink = wdata[4];
        end
        CFG_COLOR: shd_d.color = wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_x = (hcount >= act_q.xs) && (hcount < act_q.xe);
    in_y = (vcount >= act_q.ys) && (vcount < act_q.ye);
    on   = in_x && in_y && !(hide && act_q.blink);
    dx   = (hcount - act_q.xs) >> act_q.scale;
    dy   = (vcount - act_q.ys) >> act_q.scale;
    col  = int'(dx) % GLYPH_W;
    row  = int'(dy) % GLYPH_H;
    idx  = (GLYPH_H - 1 - row) * GLYPH_W + col;
    pix  = glyph[IW'(idx)];
    hit_d = 1'b0;
    unique case (act_q.mode)
      MODE_SOLID:  hit_d = on;
      MODE_GLYPH:  hit_d = on && pix;
      MODE_INVERT: hit_d = on && !pix;
      default:     hit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_q <= REGS_RST;
      act_q <= REGS_RST;
      hit_q <= 1'b0;
    end else begin
      shd_q <= shd_d;
      act_q <= act_d;
      hit_q <= hit_d;
    end
  end

  assign hit   = hit_q;
  assign color = act_q.color;

endmodule

// File: rtl/bitgen_layered.sv
// Layered VGA pixel generator: priority compositing, 2-clock latency.
// Define BITGEN_BLINK_EN to build the frame counter that blanks blink layers.
module bitgen_layered
  import bitgen_pkg::*;
#(
  parameter int                 LAYERS   = 4,
  parameter int                 GLYPH_W  = 8,
  parameter int                 GLYPH_H  = 8,
  parameter int                 CW       = 10,
  parameter int                 COLOR_W  = 24,
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(BG_COLOR_DEF)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [CW-1:0]                     hcount,
  input  logic [CW-1:0]                     vcount,
  input  logic                              bright,
  input  logic                              hsync_in,
  input  logic                              vsync_in,
  input  logic                              frame_start,
  input  logic [LAYERS*GLYPH_W*GLYPH_H-1:0] glyphs,
  input  logic                              cfg_we,
  input  logic [$clog2(LAYERS)-1:0]         cfg_layer,
  input  logic [2:0]                        cfg_field,
  input  logic [COLOR_W-1:0]                cfg_wdata,
  output logic [COLOR_W-1:0]                rgb,
  output logic                              hsync,
  output logic                              vsync,
  output logic                              bright_o
);

  localparam int LW = $clog2(LAYERS);
  localparam int GB = GLYPH_W * GLYPH_H;

  logic [LAYERS-1:0]  hit;
  logic [COLOR_W-1:0] color [LAYERS];
  logic               hide;

`ifdef BITGEN_BLINK_EN
  logic [5:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (frame_start) fcnt_d = fcnt_q + 6'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end

  assign hide = fcnt_q[5];
`else
  assign hide = 1'b0;
`endif

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    bitgen_layer #(
      .GLYPH_W (GLYPH_W),
      .GLYPH_H (GLYPH_H),
      .CW      (CW),
      .COLOR_W (COLOR_W)
    ) u_layer (
      .clk         (clk),
      .reset       (reset),
      .hcount      (hcount),
      .vcount      (vcount),
      .frame_start (frame_start),
      .glyph       (glyphs[l*GB +: GB]),
      .we          (cfg_we && (cfg_layer == LW'(l))),
      .field       (cfg_field),
      .wdata       (cfg_wdata),
      .hide        (hide),
      .hit         (hit[l]),
      .color       (color[l])
    );
  end

  // {bright, hsync, vsync} per pipeline stage
  logic [2:0]         sync1_q, sync1_d;
  logic [2:0]         sync2_q, sync2_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;

  always_comb begin
    sync1_d = {bright, hsync_in, vsync_in};
    sync2_d = sync1_q;
    rgb_d   = BG_COLOR;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) rgb_d = color[i];
    end
    if (!sync1_q[2]) rgb_d = BG_COLOR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      rgb_q   <= BG_COLOR;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb      = rgb_q;
  assign bright_o = sync2_q[2];
  assign hsync    = sync2_q[1];
  assign vsync    = sync2_q[0];

endmodule

// File: tb/tb_bitgen_layered.sv
// Self-checking bench for bitgen_layered: directed steps plus random
// scenes checked against a behavioural compositing model.
module tb_bitgen_layered;

  localparam logic [23:0] BG = 24'hF8F9FA;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   hcount, vcount;
  logic         bright, hsync_in, vsync_in, frame_start;
  logic [255:0] glyphs;
  logic         cfg_we;
  logic [1:0]   cfg_layer;
  logic [2:0]   cfg_field;
  logic [23:0]  cfg_wdata;
  logic [23:0]  rgb;
  logic         hsync, vsync, bright_o;

  always #5 clk = ~clk;

  bitgen_layered dut (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .bright      (bright),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .frame_start (frame_start),
    .glyphs      (glyphs),
    .cfg_we      (cfg_we),
    .cfg_layer   (cfg_layer),
    .cfg_field   (cfg_field),
    .cfg_wdata   (cfg_wdata),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .bright_o    (bright_o)
  );

  typedef struct {
    int          xs, xe, ys, ye;
    int          mode, scale, blink;
    logic [23:0] color;
  } lcfg_t;

  typedef struct {
    logic [23:0] rgb;
    logic        hs, vs, br;
  } exp_t;

  lcfg_t      sh [4];
  lcfg_t      act [4];
  logic [7:0] grow [4][8];
  int         fcnt;
  exp_t       q [$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(string tag, logic [23:0] obs, logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int l = 0; l < 4; l++) begin
      sh[l] = '{0, 0, 0, 0, 3, 0, 0, 24'h0};
      act[l] = sh[l];
    end
    fcnt = 0;
  endfunction

  function automatic void model_write(int l, int f, logic [23:0] d);
    case (f)
      0: sh[l].xs = int'(d[9:0]);
      1: sh[l].xe = int'(d[9:0]);
      2: sh[l].ys = int'(d[9:0]);
      3: sh[l].ye = int'(d[9:0]);
      4: begin
        sh[l].mode  = int'(d[1:0]);
        sh[l].scale = int'(d[3:2]);
        sh[l].blink = int'(d[4]);
      end
      5: sh[l].color = d;
      default: ;
    endcase
  endfunction

  function automatic void model_commit();
    for (int l = 0; l < 4; l++) act[l] = sh[l];
    fcnt = (fcnt + 1) % 64;
  endfunction

  // Colour of the highest-priority layer covering the pixel.
  function automatic logic [23:0] model_px(int h, int v, bit b);
    int dx, dy;
    bit p;
    if (!b) return BG;
    for (int l = 0; l < 4; l++) begin
      if (act[l].mode == 3) continue;
`ifdef BITGEN_BLINK_EN
      if (act[l].blink != 0 && fcnt >= 32) continue;
`endif
      if (h < act[l].xs || h >= act[l].xe) continue;
      if (v < act[l].ys || v >= act[l].ye) continue;
      dx = (h - act[l].xs) >> act[l].scale;
      dy = (v - act[l].ys) >> act[l].scale;
      p  = grow[l][dy % 8][dx % 8];
      if (act[l].mode == 0) return act[l].color;
      if (act[l].mode == 1 && p) return act[l].color;
      if (act[l].mode == 2 && !p) return act[l].color;
    end
    return BG;
  endfunction

  task automatic apply_glyphs();
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 8; r++)
        glyphs[l*64 + (7-r)*8 +: 8] = grow[l][r];
  endtask

  task automatic step(int h, int v, bit b);
    exp_t e;
    hcount   = 10'(h);
    vcount   = 10'(v);
    bright   = b;
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
    q.push_back('{model_px(h, v, b), hsync_in, vsync_in, b});
    @(posedge clk);
    #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      check("rgb", rgb, e.rgb);
      check("hsync", 24'(hsync), 24'(e.hs));
      check("vsync", 24'(vsync), 24'(e.vs));
      check("bright_o", 24'(bright_o), 24'(e.br));
    end
  endtask

  task automatic flush();
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    q.delete();
  endtask

  task automatic wr(int l, int f, logic [23:0] d);
    cfg_we    = 1'b1;
    cfg_layer = 2'(l);
    cfg_field = 3'(f);
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    model_write(l, f, d);
  endtask

  task automatic commit();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    model_commit();
  endtask

  task automatic wr_commit(int l, int f, logic [23:0] d);
    cfg_we      = 1'b1;
    cfg_layer   = 2'(l);
    cfg_field   = 3'(f);
    cfg_wdata   = d;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_we      = 1'b0;
    frame_start = 1'b0;
    model_commit();
    model_write(l, f, d);
  endtask

  task automatic set_layer(int l, int xs, int xe, int ys, int ye,
                           int mode, int scale, int blink,
                           logic [23:0] c);
    wr(l, 0, 24'(xs));
    wr(l, 1, 24'(xe));
    wr(l, 2, 24'(ys));
    wr(l, 3, 24'(ye));
    wr(l, 4, 24'(mode | (scale << 2) | (blink << 4)));
    wr(l, 5, c);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_rgb", rgb, BG);
    check("rst_bright_o", 24'(bright_o), 24'h0);
    model_reset();
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    hcount = '0; vcount = '0;
    bright = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    frame_start = 1'b0;
    cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_wdata = '0;
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 8; r++) grow[l][r] = 8'h00;
    apply_glyphs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", rgb, BG);
    check("reset_hsync", 24'(hsync), 24'h0);
    check("reset_vsync", 24'(vsync), 24'h0);
    check("reset_bright_o", 24'(bright_o), 24'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single solid region, half-open bounds
    set_layer(0, 10, 20, 10, 20, 0, 0, 0, 24'hFF0000);
    commit();
    step(10, 10, 1'b1);
    step(20, 10, 1'b1);
    step(19, 19, 1'b1);
    step(9, 10, 1'b1);
    step(15, 20, 1'b1);
    flush();
    check("solid_model", model_px(10, 10, 1'b1), 24'hFF0000);

    // priority between overlapping layers
    wr(0, 5, 24'h0000FF);
    set_layer(1, 10, 20, 10, 20, 0, 0, 0, 24'hFF0000);
    commit();
    step(12, 12, 1'b1);
    flush();
    wr(0, 4, 24'h3);
    commit();
    step(12, 12, 1'b1);
    flush();
    wr(1, 4, 24'h3);
    commit();

    // glyph, scale 1, tiling across 32 pixels
    grow[0][0] = 8'b0000_0001;
    apply_glyphs();
    set_layer(0, 0, 32, 0, 8, 1, 1, 0, 24'h00FF00);
    commit();
    for (int x = 0; x < 20; x++) step(x, 0, 1'b1);
    step(17, 1, 1'b1);
    step(17, 2, 1'b1);
    flush();
    wr(0, 4, 24'h2 | (24'h1 << 2));
    commit();
    for (int x = 0; x < 4; x++) step(x, 1, 1'b1);
    flush();

    // same-cycle write and commit
    set_layer(0, 0, 20, 0, 8, 0, 0, 0, 24'h123456);
    commit();
    wr_commit(0, 1, 24'd10);
    step(15, 0, 1'b1);
    flush();
    commit();
    step(15, 0, 1'b1);
    step(5, 0, 1'b1);
    step(5, 0, 1'b0);
    flush();

    // writes to unused fields are ignored
    wr(0, 6, 24'hFFFFFF);
    wr(0, 7, 24'h000000);
    commit();
    step(5, 0, 1'b1);
    flush();

    // random scenes
    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < 4; l++) begin
        for (int g = 0; g < 8; g++) grow[l][g] = 8'($urandom);
        set_layer(l, $urandom_range(0, 40), $urandom_range(0, 63),
                  $urandom_range(0, 40), $urandom_range(0, 63),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), 24'($urandom));
      end
      apply_glyphs();
      commit();
      for (int i = 0; i < 150; i++)
        step($urandom_range(0, 63), $urandom_range(0, 63),
             ($urandom_range(0, 3) != 0));
      flush();
    end

    // asynchronous reset mid-frame
    set_layer(0, 0, 64, 0, 64, 0, 0, 0, 24'hABCDEF);
    commit();
    step(5, 5, 1'b1);
    step(6, 6, 1'b1);
    step(7, 7, 1'b1);
    do_reset();
    step(5, 5, 1'b1);
    step(6, 6, 1'b1);
    step(7, 7, 1'b1);
    flush();

`ifdef BITGEN_BLINK_EN
    set_layer(0, 0, 64, 0, 64, 0, 0, 1, 24'h00AA55);
    commit();
    for (int f = 0; f < 64; f++) begin
      step(3, 3, 1'b1);
      flush();
      commit();
    end
    while (fcnt != 40) commit();
    step(3, 3, 1'b1);
    flush();
    do_reset();
    set_layer(0, 0, 64, 0, 64, 0, 0, 1, 24'h00AA55);
    commit();
    step(3, 3, 1'b1);
    flush();
    check("blink_after_reset", model_px(3, 3, 1'b1), 24'h00AA55);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
